// File: rtl/seg_pkg.sv
// Shared constants for the six-digit seven-segment scanner: digit count, glyphs, off codes, FSM states.
// Latency: n/a (constants only); backpressure: n/a.
package seg_pkg;

    localparam int NUM_DIG = 6;

    localparam logic [7:0] SEG_OFF = 8'hFF;
    localparam logic [5:0] SEL_OFF = 6'h3F;

    // Active-low g,f,e,d,c,b,a for hex 0..F; entry 15 is first in the concatenation.
    localparam logic [15:0][6:0] GLYPH = {
        7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00,
        7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
    };

    localparam logic [0:0] ST_BLANK = 1'b0;
    localparam logic [0:0] ST_ON    = 1'b1;

endpackage

// File: rtl/seg_scan_if.sv
// Display-side bundle: digit data, dp/lz controls in; digit selects, segments, frame pulse out.
// Latency: n/a (wires only); backpressure: none, the display never stalls.
interface seg_scan_if;
    import seg_pkg::*;

    logic [4*NUM_DIG-1:0] data_in;
    logic [NUM_DIG-1:0]   dp_in;
    logic                 lz_en;
    logic [NUM_DIG-1:0]   sel;
    logic [7:0]           seg;
    logic                 frame_done;

    modport slave  (input data_in, dp_in, lz_en, output sel, seg, frame_done);
    modport master (output data_in, dp_in, lz_en, input sel, seg, frame_done);
endinterface

// File: rtl/seg_scan_hex2seg.sv
// Hex nibble to active-low seven-segment glyph (g..a), lowercase b and d.
// Latency: combinational; backpressure: none.
module hex2seg
    import seg_pkg::*;
(
    input  logic [3:0] hex,
    output logic [6:0] seg
);

    assign seg = GLYPH[hex];

endmodule

// File: rtl/seg_scan.sv
// Multiplexed six-digit seven-segment scanner with per-slot blanking, frame-aligned data shadow and leading-zero blanking.
// Latency: one cycle from counter/FSM state to sel/seg pins; backpressure: none, free-running scan.
module seg_scan
    import seg_pkg::*;
#(
    parameter logic [31:0] SCAN_DIV  = 32'd50000,
    parameter logic [31:0] BLANK_CYC = 32'd500
) (
    input  logic        clk,
    input  logic        rst,
    seg_scan_if.slave   io
);

    localparam logic [2:0] LAST_IDX = 3'(NUM_DIG - 1);

    logic [31:0]          cnt_q,    cnt_d;
    logic [2:0]           idx_q,    idx_d;
    logic [4*NUM_DIG-1:0] shadow_q, shadow_d;
    logic [0:0]           state_q,  state_d;
    logic [NUM_DIG-1:0]   sel_q,    sel_d;
    logic [7:0]           seg_q,    seg_d;

    logic       last_cnt;
    logic       frame_end;
    logic       lz_blank;
    logic [3:0] digit;
    logic [6:0] glyph;

    hex2seg u_hex2seg (
        .hex (digit),
        .seg (glyph)
    );

    always_comb begin
        last_cnt  = (cnt_q == SCAN_DIV - 32'd1);
        frame_end = last_cnt && (idx_q == LAST_IDX);

        cnt_d = last_cnt ? 32'd0 : cnt_q + 32'd1;
        idx_d = idx_q;
        if (last_cnt) begin
            idx_d = (idx_q == LAST_IDX) ? 3'd0 : idx_q + 3'd1;
        end

        // Capture only at the frame seam so a frame never mixes two data words.
        shadow_d = frame_end ? io.data_in : shadow_q;
        state_d  = (cnt_d < BLANK_CYC) ? ST_BLANK : ST_ON;

        digit    = 4'(shadow_q >> {idx_q, 2'b00});
        lz_blank = io.lz_en && (idx_q != 3'd0) && ((shadow_q >> {idx_q, 2'b00}) == '0);

        sel_d = SEL_OFF;
        seg_d = SEG_OFF;
        if (state_q == ST_ON) begin
            sel_d = ~(NUM_DIG'(1) << idx_q);
            if (!lz_blank) begin
                seg_d = {~io.dp_in[idx_q], glyph};
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q    <= 32'd0;
            idx_q    <= 3'd0;
            shadow_q <= '0;
            // With no blank window the scan must light digit 0 straight after reset.
            state_q  <= (BLANK_CYC == 32'd0) ? ST_ON : ST_BLANK;
            sel_q    <= SEL_OFF;
            seg_q    <= SEG_OFF;
        end else begin
            cnt_q    <= cnt_d;
            idx_q    <= idx_d;
            shadow_q <= shadow_d;
            state_q  <= state_d;
            sel_q    <= sel_d;
            seg_q    <= seg_d;
        end
    end

    assign io.sel        = sel_q;
    assign io.seg        = seg_q;
    assign io.frame_done = frame_end && !rst;

endmodule

// File: tb/tb_seg_scan.sv
// Bench for seg_scan at SCAN_DIV=8: main instance with BLANK_CYC=2, second instance with BLANK_CYC=0.
module tb_seg_scan;

    logic        clk = 1'b0;
    logic        rst;
    logic [23:0] data_in;
    logic [5:0]  dp_in;
    logic        lz_en;

    int n_checks = 0;
    int n_pass   = 0;

    logic [47:0] exp_q[$];

    always #5 clk = ~clk;

    seg_scan_if io_a ();
    seg_scan_if io_b ();

    assign io_a.data_in = data_in;
    assign io_a.dp_in   = dp_in;
    assign io_a.lz_en   = lz_en;
    assign io_b.data_in = data_in;
    assign io_b.dp_in   = dp_in;
    assign io_b.lz_en   = lz_en;

    seg_scan #(.SCAN_DIV(32'd8), .BLANK_CYC(32'd2)) dut_a (.clk(clk), .rst(rst), .io(io_a));
    seg_scan #(.SCAN_DIV(32'd8), .BLANK_CYC(32'd0)) dut_b (.clk(clk), .rst(rst), .io(io_b));

    function automatic logic [6:0] glyph(input logic [3:0] h);
        case (h)
            4'h0: glyph = 7'h40;  4'h1: glyph = 7'h79;  4'h2: glyph = 7'h24;  4'h3: glyph = 7'h30;
            4'h4: glyph = 7'h19;  4'h5: glyph = 7'h12;  4'h6: glyph = 7'h02;  4'h7: glyph = 7'h78;
            4'h8: glyph = 7'h00;  4'h9: glyph = 7'h10;  4'hA: glyph = 7'h08;  4'hB: glyph = 7'h03;
            4'hC: glyph = 7'h46;  4'hD: glyph = 7'h21;  4'hE: glyph = 7'h06;  default: glyph = 7'h0E;
        endcase
    endfunction

    // Expected per-digit segment bytes for one frame, digit k in bits [8k+7:8k].
    function automatic logic [47:0] exp_frame(input logic [23:0] sh, input logic [5:0] dp, input logic lz);
        logic [47:0] f;
        f = '0;
        for (int k = 0; k < 6; k++) begin
            if (lz && k > 0 && (sh >> (4 * k)) == 24'h0)
                f[8*k +: 8] = 8'hFF;
            else
                f[8*k +: 8] = {~dp[k], glyph(sh[4*k +: 4])};
        end
        return f;
    endfunction

    // Starting one cycle into a frame's first slot, observe the 48 output cycles of that frame.
    task automatic read_frame(output logic [47:0] segs, output int bad, output int fd_cnt, output int fd_pos);
        logic [7:0] first;
        logic [5:0] oh;
        segs = '0; bad = 0; fd_cnt = 0; fd_pos = -1; first = 8'h00;
        for (int j = 0; j < 48; j++) begin
            @(negedge clk);
            oh = ~(6'd1 << (j / 8));
            if (io_a.frame_done === 1'b1) begin
                fd_cnt++;
                fd_pos = j;
            end
            if (j % 8 < 2) begin
                if (io_a.sel !== 6'h3F || io_a.seg !== 8'hFF) bad++;
            end else begin
                if (io_a.sel !== oh) bad++;
                if (j % 8 == 2) first = io_a.seg;
                else if (io_a.seg !== first) bad++;
                segs[8*(j/8) +: 8] = io_a.seg;
            end
        end
    endtask

    task automatic test_reset;
        rst = 1'b1; data_in = 24'h0; dp_in = 6'h0; lz_en = 1'b0;
        repeat (3) @(negedge clk);
        n_checks++; if (io_a.sel !== 6'h3F) $display("FAIL reset_sel got %h want 3f", io_a.sel); else n_pass++;
        n_checks++; if (io_a.seg !== 8'hFF) $display("FAIL reset_seg got %h want ff", io_a.seg); else n_pass++;
        n_checks++; if (io_a.frame_done !== 1'b0) $display("FAIL reset_fd got %b want 0", io_a.frame_done); else n_pass++;
        data_in = 24'h012345;
        rst = 1'b0;
    endtask

    task automatic test_basic;
        logic [47:0] got, exp;
        int bad, fdc, fdp;
        exp_q.push_back(exp_frame(24'h000000, 6'h0, 1'b0));
        exp_q.push_back(exp_frame(24'h012345, 6'h0, 1'b0));
        for (int f = 0; f < 2; f++) begin
            read_frame(got, bad, fdc, fdp);
            exp = exp_q.pop_front();
            n_checks++; if (got !== exp) $display("FAIL basic_frame%0d got %h want %h", f, got, exp); else n_pass++;
            n_checks++; if (bad !== 0) $display("FAIL basic_slot_shape%0d got %0d bad cycles want 0", f, bad); else n_pass++;
            n_checks++; if (fdc !== 1 || fdp !== 46) $display("FAIL basic_fd%0d got %0d pulses at %0d want 1 at 46", f, fdc, fdp); else n_pass++;
            if (f == 0) begin
                n_checks++; if (got !== 48'hC0C0C0C0C0C0) $display("FAIL first_frame_zero got %h want c0c0c0c0c0c0", got); else n_pass++;
            end else begin
                n_checks++; if (got[7:0] !== 8'h92) $display("FAIL digit0_five got %h want 92", got[7:0]); else n_pass++;
                n_checks++; if (got[39:32] !== 8'hF9) $display("FAIL digit4_one got %h want f9", got[39:32]); else n_pass++;
                n_checks++; if (got[47:40] !== 8'hC0) $display("FAIL digit5_zero got %h want c0", got[47:40]); else n_pass++;
            end
        end
    endtask

    task automatic test_midframe;
        logic [47:0] got, exp;
        int bad, fdc, fdp;
        exp_q.push_back(exp_frame(24'h012345, 6'h0, 1'b0));
        exp_q.push_back(exp_frame(24'h123450, 6'h0, 1'b0));
        for (int f = 0; f < 2; f++) begin
            if (f == 0) begin
                fork
                    read_frame(got, bad, fdc, fdp);
                    begin repeat (20) @(negedge clk); data_in = 24'h123450; end
                join
            end else begin
                read_frame(got, bad, fdc, fdp);
            end
            exp = exp_q.pop_front();
            n_checks++; if (got !== exp) $display("FAIL midframe_frame%0d got %h want %h", f, got, exp); else n_pass++;
            n_checks++; if (bad !== 0) $display("FAIL midframe_shape%0d got %0d bad cycles want 0", f, bad); else n_pass++;
            n_checks++; if (fdc !== 1 || fdp !== 46) $display("FAIL midframe_fd%0d got %0d pulses at %0d want 1 at 46", f, fdc, fdp); else n_pass++;
        end
    endtask

    task automatic test_lead_zero;
        logic [47:0] got, exp;
        int bad, fdc, fdp;
        lz_en = 1'b1;
        data_in = 24'h000105;
        exp_q.push_back(exp_frame(24'h123450, 6'h0, 1'b1));
        for (int f = 0; f < 3; f++) begin
            if (f == 1) begin data_in = 24'h000000; exp_q.push_back(exp_frame(24'h000105, 6'h0, 1'b1)); end
            if (f == 2) exp_q.push_back(exp_frame(24'h000000, 6'h0, 1'b1));
            read_frame(got, bad, fdc, fdp);
            exp = exp_q.pop_front();
            n_checks++; if (got !== exp) $display("FAIL lz_frame%0d got %h want %h", f, got, exp); else n_pass++;
            n_checks++; if (bad !== 0) $display("FAIL lz_shape%0d got %0d bad cycles want 0", f, bad); else n_pass++;
            if (f == 1) begin
                n_checks++; if (got !== 48'hFFFFFFF9C092) $display("FAIL lz_000105 got %h want fffffff9c092", got); else n_pass++;
            end
            if (f == 2) begin
                n_checks++; if (got !== 48'hFFFFFFFFFFC0) $display("FAIL lz_all_zero got %h want ffffffffffc0", got); else n_pass++;
            end
        end
    endtask

    task automatic test_dp;
        logic [47:0] got, exp;
        int bad, fdc, fdp;
        dp_in = 6'b000100; lz_en = 1'b0; data_in = 24'h012345;
        exp_q.push_back(exp_frame(24'h000000, 6'b000100, 1'b0));
        for (int f = 0; f < 3; f++) begin
            if (f == 1) begin
                lz_en = 1'b1; data_in = 24'h000005;
                exp_q.push_back(exp_frame(24'h012345, 6'b000100, 1'b1));
            end
            if (f == 2) exp_q.push_back(exp_frame(24'h000005, 6'b000100, 1'b1));
            read_frame(got, bad, fdc, fdp);
            exp = exp_q.pop_front();
            n_checks++; if (got !== exp) $display("FAIL dp_frame%0d got %h want %h", f, got, exp); else n_pass++;
            n_checks++; if (bad !== 0) $display("FAIL dp_shape%0d got %0d bad cycles want 0", f, bad); else n_pass++;
            if (f == 0) begin
                n_checks++; if (got !== 48'hC0C0C040C0C0) $display("FAIL dp_digit2_only got %h want c0c0c040c0c0", got); else n_pass++;
            end
            if (f == 2) begin
                n_checks++; if (got !== 48'hFFFFFFFFFF92) $display("FAIL dp_suppressed got %h want ffffffffff92", got); else n_pass++;
            end
        end
    endtask

    task automatic test_reset_mid;
        logic [47:0] got, exp;
        int bad, fdc, fdp;
        dp_in = 6'h0; lz_en = 1'b0; data_in = 24'h0ABCDE;
        repeat (29) @(negedge clk);
        n_checks++; if (io_a.sel !== 6'h37) $display("FAIL pre_reset_sel got %h want 37", io_a.sel); else n_pass++;
        rst = 1'b1;
        @(negedge clk);
        n_checks++; if (io_a.sel !== 6'h3F) $display("FAIL midreset_sel got %h want 3f", io_a.sel); else n_pass++;
        n_checks++; if (io_a.seg !== 8'hFF) $display("FAIL midreset_seg got %h want ff", io_a.seg); else n_pass++;
        rst = 1'b0;
        exp_q.push_back(exp_frame(24'h000000, 6'h0, 1'b0));
        exp_q.push_back(exp_frame(24'h0ABCDE, 6'h0, 1'b0));
        for (int f = 0; f < 2; f++) begin
            read_frame(got, bad, fdc, fdp);
            exp = exp_q.pop_front();
            n_checks++; if (got !== exp) $display("FAIL resume_frame%0d got %h want %h", f, got, exp); else n_pass++;
            n_checks++; if (bad !== 0) $display("FAIL resume_shape%0d got %0d bad cycles want 0", f, bad); else n_pass++;
            n_checks++; if (fdc !== 1 || fdp !== 46) $display("FAIL resume_fd%0d got %0d pulses at %0d want 1 at 46", f, fdc, fdp); else n_pass++;
        end
    endtask

    task automatic test_no_blank;
        int sel_bad, seg_bad;
        logic [5:0] oh;
        data_in = 24'h0; dp_in = 6'h0; lz_en = 1'b0;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        n_checks++; if (io_b.sel !== 6'h3F) $display("FAIL noblank_reset_sel got %h want 3f", io_b.sel); else n_pass++;
        rst = 1'b0;
        sel_bad = 0; seg_bad = 0;
        for (int m = 0; m < 100; m++) begin
            @(negedge clk);
            oh = ~(6'd1 << ((m / 8) % 6));
            if (io_b.sel !== oh) sel_bad++;
            if (io_b.seg !== 8'hC0) seg_bad++;
        end
        n_checks++; if (sel_bad !== 0) $display("FAIL noblank_sel got %0d bad cycles want 0", sel_bad); else n_pass++;
        n_checks++; if (seg_bad !== 0) $display("FAIL noblank_seg got %0d bad cycles want 0", seg_bad); else n_pass++;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_midframe();
        test_lead_zero();
        test_dp();
        test_reset_mid();
        test_no_blank();
        n_checks++; if (exp_q.size() !== 0) $display("FAIL scoreboard_drain got %0d left want 0", exp_q.size()); else n_pass++;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/seg_scan.md
SEG_SCAN -- requirements
Module: seg_scan

Interface
REQ-001 SHALL have parameter SCAN_DIV, default 32'd50000, meaning clock cycles per digit slot (1 kHz slot rate at 50 MHz); legal range >= 2.
REQ-002 SHALL have parameter BLANK_CYC, default 32'd500, meaning all-off cycles at the start of each slot for ghosting suppression; legal range 0 .. SCAN_DIV-1.
REQ-003 clk  input  1  single clock; all logic on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 data_in  input  24  six hex digits; data_in[4k+3:4k] is digit k, digit 5 leftmost.
REQ-006 dp_in  input  6  decimal point request per digit, 1 = lit.
REQ-007 lz_en  input  1  leading-zero suppression enable.
REQ-008 sel  output  6  digit enable, active-low, one-hot-low; sel[k] drives digit k.
REQ-009 seg  output  8  segments, active-low; seg[7] = dp, seg[6:0] = g,f,e,d,c,b,a.
REQ-010 frame_done  output  1  one-cycle pulse at end of each full 6-digit frame.

Function
REQ-011 Slot counter cnt SHALL count 0 .. SCAN_DIV-1 and wrap to 0; digit index idx SHALL advance 0->1->...->5->0 on each cnt wrap.
REQ-012 FSM SHALL have states BLANK and ON: BLANK while cnt < BLANK_CYC, ON otherwise; with BLANK_CYC = 0, BLANK is never entered.
REQ-013 In BLANK, sel SHALL be 6'h3F and seg SHALL be 8'hFF.
REQ-014 In ON, sel SHALL drive only bit idx low, and seg[6:0] SHALL be the hex decode of shadow digit idx.
REQ-015 Hex decode (active-low, seg[6:0]) SHALL follow standard 0-F glyphs, with lowercase b and d; examples: 0 = 7'h40, 1 = 7'h79, 5 = 7'h12, 8 = 7'h00, F = 7'h0E.
REQ-016 seg[7] SHALL be ~dp_in[idx] in ON.
REQ-017 data_in SHALL be sampled into a 24-bit shadow register only on the cycle where idx = 5 and cnt = SCAN_DIV-1, so one frame never mixes two data words.
REQ-018 frame_done SHALL pulse high on that same cycle, and SHALL be low on every other cycle.
REQ-019 With lz_en = 1, digit k (k >= 1) SHALL be blanked when shadow[23:4k] == 0: seg = 8'hFF, but sel is still driven.
REQ-020 Digit 0 SHALL never be suppressed, and dp on a suppressed digit SHALL also be off.
REQ-021 sel and seg SHALL be registered, giving exactly one cycle of latency from the FSM/idx/cnt state to the pins.
REQ-022 data_in changes mid-frame SHALL have no visible effect until the next frame boundary.
REQ-023 dp_in and lz_en SHALL take effect with the REQ-021 latency; they are not shadowed.

Reset
REQ-024 While rst = 1: cnt = 0, idx = 0, shadow = 24'h000000, state = BLANK, sel = 6'h3F, seg = 8'hFF, frame_done = 0.
REQ-025 Reset asserted mid-slot or mid-frame SHALL abort the scan, with outputs off on the next edge; after release, scanning SHALL restart at idx 0, cnt 0.
REQ-026 The first frame after reset SHALL display the shadow value 000000; the first data_in capture occurs at the end of that frame.

Structure
REQ-027 A shared package seg_pkg SHALL hold NUM_DIG = 6, the 16-entry active-low glyph table, and the SEG_OFF = 8'hFF and SEL_OFF = 6'h3F constants.
REQ-028 A combinational sub-module hex2seg (4-bit in, 7-bit active-low out) SHALL implement the glyph table.
REQ-029 Counter, FSM, shadow, suppression logic and output registers SHALL reside in seg_scan.

Verification (SCAN_DIV = 8, BLANK_CYC = 2 unless noted)
REQ-030 Reset then data_in = 24'h012345, lz_en = 0, dp_in = 0: frame 1 shows all digits 8'hC0. From frame 2: digit 0 seg = 8'h92, digit 4 = 8'hF9, digit 5 = 8'hC0. Each slot is 2 cycles of sel = 6'h3F followed by 6 cycles with one sel bit low.
REQ-031 Change data_in 012345 -> 123450 at idx 2: remainder of the frame still shows 012345. The next frame shows 123450. frame_done pulses once per 48 cycles.
REQ-032 lz_en = 1, data_in = 24'h000105: digits 5, 4, 3 show seg = 8'hFF. Digit 2 = 8'hF9, digit 1 = 8'hC0, digit 0 = 8'h92. data_in = 0 shows only digit 0 = 8'hC0.
REQ-033 dp_in = 6'b000100: only digit 2 shows seg[7] = 0. The same with lz_en = 1 and digit 2 suppressed shows seg = 8'hFF.
REQ-034 Assert rst for 1 cycle at idx 3, cnt 5: next cycle sel = 6'h3F, seg = 8'hFF. Scanning resumes at idx 0 and shows 000000 for one frame.
REQ-035 BLANK_CYC = 0: no all-off cycles, and sel is always one-hot-low after the first post-reset cycle.
